// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU opcodes, FSM state codes, request payload and opcode helpers.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
package mdu_ctrl_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [OP_W-1:0] MDU_DUM   = 4'd0;
  localparam logic [OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MDU_MADD  = 4'd5;
  localparam logic [OP_W-1:0] MDU_MADDU = 4'd6;
  localparam logic [OP_W-1:0] MDU_MSUB  = 4'd7;
  localparam logic [OP_W-1:0] MDU_MSUBU = 4'd8;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // Operation latched at accept time and held for the whole run.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
  } mdu_req_t;

  // True for opcodes this build accepts as a real MDU operation.
  function automatic logic mdu_op_valid(input logic [OP_W-1:0] op);
    logic ok;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: ok = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic mdu_op_is_div(input logic [OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: product/quotient/accumulate result and divide-by-zero flag.
// Optional feature macro: MDU_MADD_EN.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        div0
);

  logic        div_s;
  logic        is_div;
  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] dvsr;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] quo;
  logic [31:0] rem;

  // Division is done on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    div_s  = (op == MDU_DIV);
    is_div = mdu_op_is_div(op);
    div0   = is_div && (rt == 32'd0);
    prod_u = {32'd0, rs} * {32'd0, rt};
    prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    mag_a  = (div_s && rs[31]) ? (32'd0 - rs) : rs;
    mag_b  = (div_s && rt[31]) ? (32'd0 - rt) : rt;
    dvsr   = div0 ? 32'd1 : mag_b;
    quo_u  = mag_a / dvsr;
    rem_u  = mag_a % dvsr;
    quo    = (div_s && (rs[31] ^ rt[31])) ? (32'd0 - quo_u) : quo_u;
    rem    = (div_s && rs[31]) ? (32'd0 - rem_u) : rem_u;
    case (op)
      MDU_MULT:            result = prod_s;
      MDU_MULTU:           result = prod_u;
      MDU_DIV, MDU_DIVU:   result = div0 ? {hi, lo} : {rem, quo};
`ifdef MDU_MADD_EN
      MDU_MADD:            result = {hi, lo} + prod_s;
      MDU_MADDU:           result = {hi, lo} + prod_u;
      MDU_MSUB:            result = {hi, lo} - prod_s;
      MDU_MSUBU:           result = {hi, lo} - prod_u;
`endif
      default:             result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: accepts MULT/DIV ops, counts fixed latency, owns HI/LO and MTHI/MTLO.
// Optional feature macro: MDU_MADD_EN (accumulating multiplies, MUL_LAT latency).
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        mdu_clr,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  mdu_req_t         req_q, req_d;

  logic [63:0]      arith_res;
  logic             arith_div0;
  logic             accept_c;

  // Result is formed from the latched operands and HI/LO as they stand at commit.
  mdu_arith u_arith (
    .op     (req_q.op),
    .rs     (req_q.rs),
    .rt     (req_q.rt),
    .hi     (hi_q),
    .lo     (lo_q),
    .result (arith_res),
    .div0   (arith_div0)
  );

  // Next-state, counter and HI/LO update; mdu_clr overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    req_d    = req_q;
    accept_c = start && mdu_op_valid(op) && !busy_q && !mdu_clr;
    case (state_q)
      MDU_IDLE: begin
        if (!mdu_clr) begin
          if (mthi) hi_d = rs_val;
          if (mtlo) lo_d = rs_val;
        end
        if (accept_c) begin
          state_d = MDU_RUN;
          busy_d  = 1'b1;
          req_d   = '{op: op, rs: rs_val, rt: rt_val};
          cnt_d   = mdu_op_is_div(op) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
        end
      end
      MDU_RUN: begin
        if (mdu_clr) begin
          state_d = MDU_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          req_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = MDU_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (!arith_div0) begin
            hi_d = arith_res[63:32];
            lo_d = arith_res[31:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MDU_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      req_q   <= req_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus randomized ops against
// an arithmetic reference model. Honors MDU_MADD_EN if defined for the build.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic        mdu_clr;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .mdu_clr (mdu_clr),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the architectural rules.
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] acc;
    logic [63:0] r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {h, l};
    r   = acc;
    case (o)
      MDU_MULT:  r = 64'(sa * sb);
      MDU_MULTU: r = ua * ub;
      MDU_DIV:   if (b != 32'd0) r = {32'(sa % sb), 32'(sa / sb)};
      MDU_DIVU:  if (b != 32'd0) r = {32'(ua % ub), 32'(ua / ub)};
      MDU_MADD:  r = acc + 64'(sa * sb);
      MDU_MADDU: r = acc + ua * ub;
      MDU_MSUB:  r = acc - 64'(sa * sb);
      MDU_MSUBU: r = acc - ua * ub;
      default:   r = acc;
    endcase
    return r;
  endfunction

  // Issue one op and follow it cycle by cycle to its commit.
  // mt_start: raise MTHI together with start; mt_busy: try MTHI/MTLO while busy.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit mt_start, input bit mt_busy);
    int          lat;
    logic [63:0] exp;
    lat    = (o == MDU_DIV || o == MDU_DIVU) ? DIV_LAT : MUL_LAT;
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    mthi   = mt_start;
    tick();
    if (mt_start) begin
      m_hi = a;
      check({tag, " mt_with_start"}, hi, m_hi);
    end
    start  = 1'b0;
    op     = MDU_DUM;
    mthi   = mt_busy;
    mtlo   = mt_busy;
    rs_val = $urandom;
    rt_val = $urandom;
    check({tag, " busy_rise"}, {busy, done}, 2'b10);
    for (int i = 1; i < lat; i++) begin
      tick();
      check({tag, " running"}, {busy, done}, 2'b10);
      if (mt_busy) check({tag, " mt_ignored"}, {hi, lo}, {m_hi, m_lo});
    end
    mthi = 1'b0;
    mtlo = 1'b0;
    exp  = ref_result(o, a, b, m_hi, m_lo);
    tick();
    check({tag, " commit_flags"}, {busy, done}, 2'b01);
    check({tag, " result"}, {hi, lo}, exp);
    {m_hi, m_lo} = exp;
    tick();
    check({tag, " done_pulse"}, {busy, done}, 2'b00);
  endtask

  task automatic mt_write(input logic [31:0] v, input bit wh, input bit wl);
    mthi   = wh;
    mtlo   = wl;
    rs_val = v;
    tick();
    mthi = 1'b0;
    mtlo = 1'b0;
    if (wh) m_hi = v;
    if (wl) m_lo = v;
    check("mt_write", {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] saved;

    rst_n = 1'b0; start = 1'b0; op = MDU_DUM; rs_val = '0; rt_val = '0;
    mthi = 1'b0; mtlo = 1'b0; mdu_clr = 1'b0;
    m_hi = '0; m_lo = '0;
    tick();
    tick();
    check("reset_state", {busy, done, hi, lo}, 66'd0);
    rst_n = 1'b1;
    tick();

    // Directed arithmetic cases with hand-derived results.
    run_op("mult_neg2x3", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    check("mult_neg2x3 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("div_neg7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_neg7_2 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    saved = {hi, lo};
    run_op("divu_by_zero", MDU_DIVU, 32'd7, 32'd0, 1'b0, 1'b0);
    check("divu_by_zero const", {hi, lo}, saved);
    run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_ovf const", {hi, lo}, 64'h0000_0000_8000_0000);

    // MTHI then read.
    mt_write(32'h0000_1234, 1'b1, 1'b0);
    check("mthi_const", hi, 32'h0000_1234);

    // MT writes while busy are dropped; MT with start lands first, then op overwrites.
    run_op("mt_while_busy", MDU_MULT, 32'd11, 32'd13, 1'b0, 1'b1);
    run_op("mt_with_start", MDU_MULTU, 32'd21, 32'd3, 1'b1, 1'b0);

    // Invalid opcode start is a no-op.
    start = 1'b1; op = MDU_DUM; rs_val = 32'd9; rt_val = 32'd9;
    tick();
    start = 1'b0;
    check("dum_start", {busy, hi, lo}, {1'b0, m_hi, m_lo});

`ifdef MDU_MADD_EN
    mt_write(32'd1, 1'b0, 1'b1);
    mt_write(32'd0, 1'b1, 1'b0);
    run_op("maddu_1x1", MDU_MADDU, 32'd1, 32'd1, 1'b0, 1'b0);
    check("maddu_1x1 const", lo, 32'd2);
    run_op("msub", MDU_MSUB, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
`else
    start = 1'b1; op = MDU_MADDU; rs_val = 32'd1; rt_val = 32'd1;
    tick();
    start = 1'b0; op = MDU_DUM;
    check("madd_disabled", {busy, hi, lo}, {1'b0, m_hi, m_lo});
    tick();
    check("madd_disabled done", {busy, done}, 2'b00);
`endif

    // Abort with mdu_clr two cycles after accept: no commit, no done.
    start = 1'b1; op = MDU_MULT; rs_val = 32'd100; rt_val = 32'd100;
    tick();
    start = 1'b0; op = MDU_DUM;
    tick();
    tick();
    mdu_clr = 1'b1;
    tick();
    mdu_clr = 1'b0;
    check("clr_busy", {busy, done}, 2'b00);
    for (int i = 0; i < MUL_LAT; i++) begin
      tick();
      check("clr_no_commit", {busy, done, hi, lo}, {2'b00, m_hi, m_lo});
    end

    // mdu_clr together with start drops the start.
    start = 1'b1; op = MDU_DIV; rs_val = 32'd50; rt_val = 32'd5; mdu_clr = 1'b1;
    tick();
    start = 1'b0; mdu_clr = 1'b0;
    check("clr_with_start", busy, 1'b0);

    // Back-to-back: start held through the whole first op is ignored until busy falls.
    start = 1'b1; op = MDU_MULT; rs_val = 32'd7; rt_val = 32'd6;
    tick();
    saved = ref_result(MDU_MULT, 32'd7, 32'd6, m_hi, m_lo);
    rs_val = 32'd1000; rt_val = 32'd1000;
    for (int i = 1; i < MUL_LAT; i++) tick();
    tick();
    start = 1'b0; op = MDU_DUM;
    check("b2b first result", {busy, done, hi, lo}, {2'b01, saved});
    {m_hi, m_lo} = saved;
    tick();
    check("b2b no second", {busy, done}, 2'b00);

    // Reset in the middle of a DIV.
    mt_write(32'hCAFE_0001, 1'b1, 1'b1);
    start = 1'b1; op = MDU_DIV; rs_val = 32'd99; rt_val = 32'd3;
    tick();
    start = 1'b0; op = MDU_DUM;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    check("reset_mid_div", {busy, done, hi, lo}, 66'd0);
    for (int i = 0; i < DIV_LAT; i++) tick();
    check("reset_mid_div later", {busy, done, hi, lo}, 66'd0);

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
`ifdef MDU_MADD_EN
      r_op = 4'($urandom_range(1, 8));
`else
      r_op = 4'($urandom_range(1, 4));
`endif
      r_a = $urandom;
      r_b = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: r_a = 32'h8000_0000;
        2: r_b = 32'hFFFF_FFFF;
        3: r_b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) mt_write($urandom, 1'($urandom), 1'($urandom));
      run_op("random", r_op, r_a, r_b, 1'($urandom_range(0, 4) == 0), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
